// File: rtl/adc_scan_scheduler.sv
// ADC scan scheduler: walks the AVR channel select through the enabled
// channels, accepts samples tagged with the requested channel into a
// one-entry holding register, and skips channels whose conversion stalls.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not scanning; channel holds the last requested index
// WAIT  | channel requested, waiting for a matching sample or timeout
module adc_scan_scheduler #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] en_mask,
  output logic [3:0]  channel,
  input  logic        new_sample,
  input  logic [9:0]  sample,
  input  logic [3:0]  sample_channel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_sample,
  output logic [3:0]  out_channel,
  output logic        scan_done,
  output logic        timeout,
  output logic        overflow,
  input  logic        clear_ovf,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TC_SAT  = TW'(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  logic          accept;
  logic          tmo_hit;
  logic          advance;
  logic [4:0]    above;
  logic [3:0]    nxt_ch;
  logic          wrap;
  logic          ovf_set;

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest enabled channel strictly above cur
  function automatic logic [4:0] next_above(input logic [15:0] m, input logic [3:0] cur);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (4'(i) > cur)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  assign accept  = (state == WAIT) && new_sample && (sample_channel == channel);
  assign tmo_hit = (state == WAIT) && (timer == TC_LAST) && !accept;
  assign advance = accept || tmo_hit;

  // When nothing is enabled above the current channel the scan wraps, and the
  // wrapped-to index is necessarily <= current, which is exactly scan_done.
  assign above  = next_above(en_mask, channel);
  assign nxt_ch = above[4] ? above[3:0] : lowest_set(en_mask);
  assign wrap   = !above[4];

  // Overwrite of a sample the consumer has not taken this cycle.
  assign ovf_set = accept && out_valid && !out_ready;

  assign busy = (state == WAIT);

  // Scan sequencing: channel select, stall timer and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      channel   <= '0;
      timer     <= '0;
      scan_done <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (run && (en_mask != '0)) begin
            state   <= WAIT;
            channel <= lowest_set(en_mask);
            timer   <= '0;
          end
        end
        WAIT: begin
          if (advance) begin
            timeout <= tmo_hit;
            if (!run || (en_mask == '0)) begin
              state <= IDLE;
            end else begin
              channel   <= nxt_ch;
              scan_done <= wrap;
              timer     <= '0;
            end
          end else if (timer != TC_SAT) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry holding register towards the user logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_sample  <= '0;
      out_channel <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_sample  <= sample;
      out_channel <= sample_channel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; a new overwrite beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler.
module tb_adc_scan_scheduler;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] en_mask = '0;
  logic [3:0]  channel;
  logic        new_sample = 1'b0;
  logic [9:0]  sample = '0;
  logic [3:0]  sample_channel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_sample;
  logic [3:0]  out_channel;
  logic        scan_done;
  logic        timeout;
  logic        overflow;
  logic        clear_ovf = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  adc_scan_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .en_mask(en_mask), .channel(channel),
    .new_sample(new_sample), .sample(sample), .sample_channel(sample_channel),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_channel(out_channel), .scan_done(scan_done), .timeout(timeout),
    .overflow(overflow), .clear_ovf(clear_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      mask;
    logic [4:0][3:0]  ch;   // expected channel sequence, ch[0] first
    logic [3:0]       sd;   // expected scan_done after step k
  } vec_t;

  vec_t tbl[4];

  function automatic vec_t mkvec(input logic [15:0] m, input logic [3:0] c0, c1, c2, c3, c4,
                                 input logic [3:0] sd);
    vec_t v;
    v.mask = m;
    v.ch   = {c4, c3, c2, c1, c0};
    v.sd   = sd;
    return v;
  endfunction

  // Reference: next enabled channel going upward from cur, wrapping mod 16.
  function automatic logic [3:0] model_next(input logic [15:0] m, input logic [3:0] cur);
    int idx;
    for (int d = 1; d <= 16; d++) begin
      idx = (int'(cur) + d) % 16;
      if (m[idx]) return 4'(idx);
    end
    return cur;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [3:0] ch, input logic [9:0] v);
    new_sample     = 1'b1;
    sample_channel = ch;
    sample         = v;
    cyc();
    new_sample     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; en_mask = '0; new_sample = 1'b0;
    out_ready = 1'b0; clear_ovf = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    m = 16'($urandom) & 16'($urandom);
    if (m == '0) m = 16'h1 << $urandom_range(0, 15);
    return m;
  endfunction

  initial begin
    logic [9:0]  v;
    logic [15:0] mask;
    logic [3:0]  exp_ch, nxt;
    int          d, elapsed;

    tbl[0] = mkvec(16'h0025, 4'd0, 4'd2,  4'd5, 4'd0,  4'd2, 4'b0100);
    tbl[1] = mkvec(16'h8001, 4'd0, 4'd15, 4'd0, 4'd15, 4'd0, 4'b1010);
    tbl[2] = mkvec(16'h0010, 4'd4, 4'd4,  4'd4, 4'd4,  4'd4, 4'b1111);
    tbl[3] = mkvec(16'h1248, 4'd3, 4'd6,  4'd9, 4'd12, 4'd3, 4'b1000);

    // Reset values
    do_reset();
    chk("rst_channel", channel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_timeout", timeout, 0);

    // Table-driven scans; AVR echoes the requested channel after 10 cycles
    for (int i = 0; i < 4; i++) begin
      do_reset();
      en_mask = tbl[i].mask; run = 1'b1; out_ready = 1'b1;
      cyc();
      chk("tbl_busy", busy, 1);
      for (int k = 0; k < 4; k++) begin
        chk("tbl_channel", channel, tbl[i].ch[k]);
        cyc(10);
        v = 10'(i * 100 + k * 37 + 5);
        send(tbl[i].ch[k], v);
        chk("tbl_out_valid", out_valid, 1);
        chk("tbl_out_channel", out_channel, tbl[i].ch[k]);
        chk("tbl_out_sample", out_sample, v);
        chk("tbl_next_channel", channel, tbl[i].ch[k+1]);
        chk("tbl_scan_done", scan_done, tbl[i].sd[k]);
        chk("tbl_timeout", timeout, 0);
      end
    end

    // Stale in-flight sample after a 0->2 switch
    do_reset();
    en_mask = 16'h0025; run = 1'b1; out_ready = 1'b1;
    cyc();
    send(4'd0, 10'h011);
    chk("stale_switch", channel, 2);
    cyc();
    chk("stale_drained", out_valid, 0);
    send(4'd0, 10'h0FF);
    chk("stale_discard_valid", out_valid, 0);
    chk("stale_discard_ch", channel, 2);
    send(4'd2, 10'h3A5);
    chk("stale_accept_sample", out_sample, 10'h3A5);
    chk("stale_accept_channel", out_channel, 2);
    chk("stale_accept_valid", out_valid, 1);

    // Timeout on channel 1, 20 cycles after entering it
    do_reset();
    en_mask = 16'h0003; run = 1'b1; out_ready = 1'b1;
    cyc();
    send(4'd0, 10'h001);
    chk("tmo_enter_ch1", channel, 1);
    cyc(TMO - 1);
    chk("tmo_not_early", timeout, 0);
    chk("tmo_still_ch1", channel, 1);
    cyc();
    chk("tmo_pulse", timeout, 1);
    chk("tmo_back_ch0", channel, 0);
    chk("tmo_scan_done", scan_done, 1);
    cyc();
    chk("tmo_one_cycle", timeout, 0);

    // Overflow behaviour
    do_reset();
    en_mask = 16'h0001; run = 1'b1; out_ready = 1'b0;
    cyc();
    send(4'd0, 10'h001);
    chk("ovf_first_valid", out_valid, 1);
    chk("ovf_first_flag", overflow, 0);
    chk("ovf_single_scan_done", scan_done, 1);
    send(4'd0, 10'h002);
    chk("ovf_overwrite_sample", out_sample, 10'h002);
    chk("ovf_set", overflow, 1);
    clear_ovf = 1'b1;
    send(4'd0, 10'h003);
    clear_ovf = 1'b0;
    chk("ovf_set_beats_clear", overflow, 1);
    chk("ovf_third_sample", out_sample, 10'h003);
    clear_ovf = 1'b1;
    cyc();
    clear_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    chk("ovf_hold_sample", out_sample, 10'h003);
    out_ready = 1'b1;
    send(4'd0, 10'h004);
    chk("ovf_replace_valid", out_valid, 1);
    chk("ovf_replace_sample", out_sample, 10'h004);
    chk("ovf_replace_no_flag", overflow, 0);
    cyc();
    chk("ovf_consumed", out_valid, 0);

    // Run dropped while waiting on channel 3
    do_reset();
    en_mask = 16'h0009; run = 1'b1; out_ready = 1'b0;
    cyc();
    send(4'd0, 10'h055);
    chk("run_ch3", channel, 3);
    run = 1'b0;
    cyc(5);
    chk("run_still_busy", busy, 1);
    send(4'd3, 10'h1C3);
    chk("run_buffered", out_sample, 10'h1C3);
    chk("run_buffered_ch", out_channel, 3);
    chk("run_idle", busy, 0);
    chk("run_channel_hold", channel, 3);
    chk("run_no_scan_done", scan_done, 0);
    en_mask = 16'h0000; run = 1'b1;
    cyc(3);
    chk("zero_mask_idle", busy, 0);
    chk("zero_mask_channel", channel, 3);

    // Asynchronous reset mid-WAIT with a buffered sample
    do_reset();
    en_mask = 16'h0030; run = 1'b1; out_ready = 1'b0;
    cyc();
    send(4'd4, 10'h2AA);
    chk("arst_pre_valid", out_valid, 1);
    chk("arst_pre_channel", channel, 5);
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_channel", channel, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sample", out_sample, 0);
    chk("arst_out_channel", out_channel, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("arst_restart_ch", channel, 4);
    chk("arst_restart_busy", busy, 1);

    // Randomized scanning against the reference model
    do_reset();
    mask = rand_mask();
    en_mask = mask; run = 1'b1; out_ready = 1'b1;
    cyc();
    exp_ch = model_next(mask, 4'd15);
    for (int step = 0; step < 40; step++) begin
      chk("rnd_channel", channel, exp_ch);
      elapsed = 0;
      if ($urandom_range(0, 1) == 1) begin
        send(exp_ch ^ 4'($urandom_range(1, 15)), 10'($urandom));
        elapsed++;
        chk("rnd_stale_valid", out_valid, 0);
        chk("rnd_stale_channel", channel, exp_ch);
      end
      d = $urandom_range(0, 8);
      cyc(d);
      elapsed += d;
      if ($urandom_range(0, 4) == 0) begin
        mask = rand_mask();
        en_mask = mask;
      end
      nxt = model_next(mask, exp_ch);
      if ($urandom_range(0, 6) == 0) begin
        cyc(TMO - 1 - elapsed);
        chk("rnd_no_early_tmo", timeout, 0);
        cyc();
        chk("rnd_tmo", timeout, 1);
        chk("rnd_tmo_valid", out_valid, 0);
      end else begin
        v = 10'($urandom);
        send(exp_ch, v);
        chk("rnd_valid", out_valid, 1);
        chk("rnd_sample", out_sample, v);
        chk("rnd_out_channel", out_channel, exp_ch);
        chk("rnd_no_tmo", timeout, 0);
      end
      chk("rnd_next_channel", channel, nxt);
      chk("rnd_scan_done", scan_done, (nxt <= exp_ch) ? 1 : 0);
      exp_ch = nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Sequences the AVR ADC channel select through a programmable set of enabled channels.
- Matches each returned sample against the requested channel and buffers accepted samples in a one-entry valid/ready holding register for the user logic.
- Sits between the AVR interface ADC signals (channel, new_sample, sample, sample_channel) and user logic.
- Detects stalled conversions with a timeout and flags dropped results.

Parameters:
TIMEOUT_CYCLES, 50000, cycles to wait for a matching sample before skipping the channel (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = scan continuously; 0 = stop after current channel
en_mask  in  16  per-channel enable, bit i = ADC channel i
channel  out  4  channel request to AVR interface
new_sample  in  1  one-cycle strobe from AVR interface
sample  in  10  sample value, valid with new_sample
sample_channel  in  4  channel the sample belongs to
out_valid  out  1  holding register full
out_ready  in  1  consumer accepts when out_valid & out_ready
out_sample  out  10  buffered sample
out_channel  out  4  buffered sample's channel
scan_done  out  1  one-cycle pulse: scan wrapped past highest enabled channel
timeout  out  1  one-cycle pulse: current channel skipped on timeout
overflow  out  1  sticky: unconsumed sample overwritten
clear_ovf  in  1  clears overflow
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, channel=0, out_valid=0, out_sample=0, out_channel=0, scan_done=0, timeout=0, overflow=0, timer=0. All other flops also clear.
- All outputs are registered.
- States: IDLE, WAIT.
- IDLE -> WAIT when run=1 and en_mask!=0:
  - channel loads the lowest set bit of en_mask.
  - timer clears.
  - Next cycle: WAIT.
- IDLE with en_mask==0 stays IDLE regardless of run.
- WAIT, timer counts up each cycle. Width = clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
- WAIT, new_sample=1 and sample_channel==channel (accept):
  - Load out_sample/out_channel and set out_valid.
  - Then advance.
- WAIT, new_sample=1 and sample_channel!=channel: discard the sample; timer is not reset. This covers the stale in-flight sample after a channel switch.
- WAIT, timer==TIMEOUT_CYCLES-1 with no accept that cycle: timeout pulses for 1 cycle, then advance. An accept in the same cycle wins; no timeout pulse.
- Advance:
  - Sample en_mask now; changes take effect only here.
  - Next channel = lowest set bit above channel; if none, lowest set bit overall (wrap).
  - If the chosen index <= current channel, pulse scan_done (same cycle as channel update). With a single enabled channel this pulses on every advance.
  - If run=0 or sampled en_mask==0: go to IDLE, channel holds its last value, no scan_done.
  - Otherwise stay in WAIT with the new channel and clear timer.
- Holding register:
  - out_valid & out_ready clears out_valid, unless a load occurs in the same cycle.
  - Load while out_valid=1 and out_ready=0: overwrite, out_valid stays 1, overflow set.
  - Load with out_ready=1 in the same cycle: new data replaces old, out_valid=1, no overflow.
  - out_sample/out_channel are stable while out_valid=1 and no load.
- overflow: cleared by clear_ovf. If set and clear occur in the same cycle, set wins.
- Deasserting run mid-WAIT never aborts: the current channel completes (accept or timeout) before IDLE.
- rst_n asserted mid-operation: immediate return to reset values; any buffered sample is lost.

Test Plan:
- en_mask=16'h0025, run=1, AVR model echoes channel after 10 cycles -> channel sequence 0,2,5,0,...; out_channel matches; scan_done pulses on each 5->0 step; no timeout.
- After a 0->2 switch, inject a sample tagged channel 0 -> discarded (out_valid unchanged); then inject ch2 sample 10'h3A5 -> out_sample=10'h3A5, out_channel=2.
- TIMEOUT_CYCLES=20, en_mask=16'h0003, never send ch1 -> timeout pulses exactly 20 cycles after entering ch1; channel returns to 0; scan_done pulses.
- out_ready=0, two accepted samples 10'h001 then 10'h002 -> out_sample=10'h002, overflow=1. Then clear_ovf=1 and an overflowing load in the same cycle -> overflow stays 1.
- run dropped while waiting on ch3, sample arrives 5 cycles later -> sample buffered, then IDLE, channel=3, busy=0, no scan_done. en_mask=0 with run=1 -> stays IDLE.
- rst_n pulsed low mid-WAIT with out_valid=1 -> all outputs 0 asynchronously; restart scans from the lowest enabled channel.
